// File: rtl/isa_pkg.sv
// Shared ISA and instruction-memory parameters, plus the program-loader state encoding.
// Single-sourced here so the processor, its memory and the loader all agree on them.
package isa_pkg;

  localparam int ADDR_W     = 10;
  localparam int WORD_W     = 34;
  localparam int DEPTH      = 65;
  localparam int BPW        = 5;
  localparam int BYTE_IDX_W = $clog2(BPW);

  typedef enum logic [2:0] {
    LD_IDLE   = 3'd0,
    LD_CNT_LO = 3'd1,
    LD_CNT_HI = 3'd2,
    LD_DATA   = 3'd3,
    LD_WRITE  = 3'd4,
    LD_CHECK  = 3'd5
  } ld_state_t;

endpackage

// File: rtl/byte_word_assembler.sv
// Collects BPW little-endian bytes into one instruction word and flags the
// cycle on which the last byte arrives; the word is valid alongside that flag.
module byte_word_assembler
  import isa_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_valid
);

  localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BPW - 1);

  logic [BYTE_IDX_W-1:0]  byte_idx;
  logic [8*(BPW-1)-1:0]   shreg;

  assign word_valid = byte_valid && (byte_idx == LAST_IDX);
  // The final byte is used straight from the input; its bits above WORD_W are dropped.
  assign word       = WORD_W'({byte_in, shreg});

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      byte_idx <= '0;
    end else if (byte_valid) begin
      byte_idx <= word_valid ? '0 : byte_idx + BYTE_IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (byte_valid) begin
      shreg <= {byte_in, shreg[8*(BPW-1)-1:8]};
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a program byte stream (count, words, XOR checksum) into instruction memory
// from address 0 up, holding the processor in reset while the load runs.
module instr_mem_loader
  import isa_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] words_loaded
);

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  ld_state_t         state, state_nxt;
  logic              xfer, start_acc, cnt_bad, last_word;
  logic [7:0]        cnt_lo, chk;
  logic [ADDR_W-1:0] n_words, cnt_n;
  logic [WORD_W-1:0] asm_word;
  logic              asm_valid;

  assign xfer      = rx_valid && rx_ready;
  assign start_acc = (state == LD_IDLE) && start;
  assign cnt_n     = ADDR_W'({rx_data[1:0], cnt_lo});
  assign cnt_bad   = (rx_data[7:2] != 6'd0) || (cnt_n > DEPTH_A);
  assign last_word = (words_loaded + ADDR_W'(1)) == n_words;

  byte_word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_acc),
    .byte_valid (xfer && (state == LD_DATA)),
    .byte_in    (rx_data),
    .word       (asm_word),
    .word_valid (asm_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= LD_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LD_IDLE:   if (start) state_nxt = LD_CNT_LO;
      LD_CNT_LO: if (xfer) state_nxt = LD_CNT_HI;
      LD_CNT_HI: if (xfer) begin
        if (cnt_bad)                 state_nxt = LD_IDLE;
        else if (cnt_n == '0)        state_nxt = LD_CHECK;
        else                         state_nxt = LD_DATA;
      end
      LD_DATA:   if (asm_valid) state_nxt = LD_WRITE;
      LD_WRITE:  state_nxt = last_word ? LD_CHECK : LD_DATA;
      LD_CHECK:  if (xfer) state_nxt = LD_IDLE;
      default:   state_nxt = LD_IDLE;
    endcase
  end

  always_comb begin
    rx_ready = 1'b0;
    mem_we   = 1'b0;
    busy     = (state != LD_IDLE);
    case (state)
      LD_CNT_LO, LD_CNT_HI, LD_DATA, LD_CHECK: rx_ready = 1'b1;
      LD_WRITE:                                mem_we   = 1'b1;
      default: ;
    endcase
  end

  assign cpu_hold = busy;

  // Counters, checksum and the registered write port; the checksum byte itself is not folded in.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_lo       <= '0;
      n_words      <= '0;
      words_loaded <= '0;
      chk          <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      if (start_acc) begin
        done         <= 1'b0;
        error        <= 1'b0;
        words_loaded <= '0;
        chk          <= '0;
      end
      if (xfer && (state != LD_CHECK)) chk <= chk ^ rx_data;
      if (xfer && (state == LD_CNT_LO)) cnt_lo <= rx_data;
      if (xfer && (state == LD_CNT_HI)) begin
        n_words <= cnt_n;
        if (cnt_bad) error <= 1'b1;
      end
      if (asm_valid) begin
        mem_addr  <= words_loaded;
        mem_wdata <= asm_word;
      end
      if (state == LD_WRITE) words_loaded <= words_loaded + ADDR_W'(1);
      if (xfer && (state == LD_CHECK)) begin
        if (rx_data == chk) done  <= 1'b1;
        else                error <= 1'b1;
      end
    end
  end

endmodule
